// File: rtl/matrix_feeder.sv
// matrix_feeder: host-loaded 16 x 8-bit operand buffer streamed to a processing
// unit, followed by a wait for its completion flag and capture of its result.
//
// Optional feature: define MATRIX_FEEDER_TIMEOUT_EN to compile in a 256-cycle
// WAIT watchdog that sets a sticky error flag and abandons the transfer.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   wr_en      buffer write strobe (accepted in IDLE only)
//   wr_addr    buffer write address 0..15
//   wr_data    buffer write data
//   start      stream request (accepted in IDLE only)
//   finished   completion flag from the processing unit (accepted in WAIT only)
//   result_in  result byte from the processing unit
//   data_out   operand byte, 8'h00 outside STREAM
//   trigger    operand-valid strobe, high for the 16 STREAM cycles
//   result_q   captured result
//   busy       high whenever the FSM is not in IDLE
//   done       one-cycle completion pulse
//   error      sticky watchdog timeout flag (0 when the watchdog is compiled out)
module matrix_feeder (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [3:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       start,
   input  logic       finished,
   input  logic [7:0] result_in,
   output logic [7:0] data_out,
   output logic       trigger,
   output logic [7:0] result_q,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 16;

   typedef enum logic [1:0] {IDLE, STREAM, WAIT, DONE} state_t;

   state_t          state;
   state_t          state_nx;
   logic [AW-1:0]   idx;
   logic [AW-1:0]   idx_nx;
   logic [DW-1:0]   mem [DEPTH];
   logic [DW-1:0]   rd_data_c;
   logic [DW-1:0]   data_nx;
   logic            wr_ok;
   logic            capture;
   logic            timeout_c;

`ifdef MATRIX_FEEDER_TIMEOUT_EN
   localparam int unsigned TW = 8;

   logic [TW-1:0] tmo_cnt;

   // Watchdog counter: held at zero outside WAIT so it starts from 0 on entry.
   always_ff @(posedge clk) begin
      if (!reset)             tmo_cnt <= '0;
      else if (state != WAIT) tmo_cnt <= '0;
      else                    tmo_cnt <= tmo_cnt + TW'(1);
   end

   // Last of 256 WAIT cycles is the one where the counter reads all-ones.
   assign timeout_c = (tmo_cnt == {TW{1'b1}});

   // Sticky error: set on timeout, cleared by reset or an accepted start.
   always_ff @(posedge clk) begin
      if (!reset)                                    error <= 1'b0;
      else if (state == IDLE && start)               error <= 1'b0;
      else if (state == WAIT && !finished && timeout_c) error <= 1'b1;
   end
`else
   assign timeout_c = 1'b0;
   assign error     = 1'b0;
`endif

   // Next-state and buffer/result control.
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      wr_ok    = 1'b0;
      capture  = 1'b0;
      case (state)
         IDLE: begin
            wr_ok = wr_en;
            if (start) begin
               state_nx = STREAM;
               idx_nx   = '0;
            end
         end
         STREAM: begin
            idx_nx = idx + AW'(1);
            if (idx == AW'(DEPTH - 1)) state_nx = WAIT;
         end
         WAIT: begin
            if (finished) begin
               capture  = 1'b1;
               state_nx = DONE;
            end else if (timeout_c) begin
               state_nx = IDLE;
            end
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand for the next cycle; a write coinciding with start is forwarded
   // so the first streamed byte already reflects it.
   always_comb begin
      rd_data_c = mem[idx_nx];
      if (wr_ok && (wr_addr == idx_nx)) rd_data_c = wr_data;
      data_nx = (state_nx == STREAM) ? rd_data_c : '0;
   end

   // State, buffer and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         idx      <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         result_q <= '0;
         data_out <= '0;
         trigger  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nx;
         idx      <= idx_nx;
         if (wr_ok)   mem[wr_addr] <= wr_data;
         if (capture) result_q     <= result_in;
         data_out <= data_nx;
         trigger  <= (state_nx == STREAM);
         busy     <= (state_nx != IDLE);
         done     <= (state_nx == DONE);
      end
   end

endmodule

// File: tb/tb_matrix_feeder.sv
// Self-checking bench for matrix_feeder: transaction-level reference model,
// per-cycle output comparison, directed scenarios and a randomized phase.
module tb_matrix_feeder;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       wr_en = 1'b0;
   logic [3:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       start = 1'b0;
   logic       finished = 1'b0;
   logic [7:0] result_in = '0;
   logic [7:0] data_out;
   logic       trigger;
   logic [7:0] result_q;
   logic       busy;
   logic       done;
   logic       error;

   int n_vec = 0;
   int n_err = 0;

   matrix_feeder dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .start(start), .finished(finished),
      .result_in(result_in), .data_out(data_out), .trigger(trigger),
      .result_q(result_q), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [7:0] m_mem [16];
   logic [7:0] pend [$];
   logic [7:0] m_data = '0, m_res = '0;
   bit m_trig = 0, m_busy = 0, m_done = 0, m_err = 0, waiting = 0, m_ok = 0;
   int wait_cnt = 0;

   always @(posedge clk) begin
      bit was_trig;
      if (!reset) begin
         for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
         pend.delete();
         waiting = 0; wait_cnt = 0;
         m_trig = 0; m_data = 0; m_busy = 0; m_done = 0; m_res = 0; m_err = 0;
         m_ok = 1;
      end else begin
         was_trig = m_trig;
         m_trig = 0; m_data = 0; m_done = 0;
         if (!m_busy) begin
            if (wr_en) m_mem[wr_addr] = wr_data;
            if (start) begin
               for (int i = 0; i < 16; i++) pend.push_back(m_mem[i]);
               m_err = 0;
            end
         end else if (waiting) begin
            if (finished) begin
               m_res = result_in; waiting = 0; m_done = 1;
            end else begin
               wait_cnt++;
`ifdef MATRIX_FEEDER_TIMEOUT_EN
               if (wait_cnt == 256) begin m_err = 1; waiting = 0; end
`endif
            end
         end else if (was_trig && pend.size() == 0) begin
            waiting = 1; wait_cnt = 0;
         end
         if (pend.size() > 0) begin
            m_trig = 1; m_data = pend.pop_front();
         end
         m_busy = m_trig || waiting || m_done;
      end
   end

   // ---------------- per-cycle comparison ----------------
   always @(negedge clk) begin
      if (m_ok) begin
         n_vec++;
         if ({trigger, data_out, busy, done, result_q, error} !==
             {m_trig, m_data, m_busy, m_done, m_res, m_err}) begin
            n_err++;
            $display("FAIL cycle t=%0t got trig=%b data=%h busy=%b done=%b res=%h err=%b want trig=%b data=%h busy=%b done=%b res=%h err=%b",
                     $time, trigger, data_out, busy, done, result_q, error,
                     m_trig, m_data, m_busy, m_done, m_res, m_err);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got=%0d want=%0d", nm, got, want);
      end
   endtask

   // Called with the first trigger cycle visible; leaves the bench at WAIT cycle 1.
   task automatic run_stream(input string nm, input logic [7:0] exp_d [16]);
      int cnt = 0;
      for (int c = 0; c < 40 && trigger === 1'b1; c++) begin
         if (cnt < 16) chk({nm, "_data"}, 32'(data_out), 32'(exp_d[cnt]));
         cnt++;
         tick();
      end
      chk({nm, "_len"}, 32'(cnt), 32'd16);
   endtask

   task automatic finish_wait(input logic [7:0] r);
      finished = 1; result_in = r;
      tick();
      finished = 0;
      chk("fin_res", 32'(result_q), 32'(r));
      chk("fin_done", 32'(done), 32'd1);
      tick();
      chk("fin_done_low", 32'(done), 32'd0);
      chk("fin_idle", 32'(busy), 32'd0);
   endtask

   logic [7:0] vals [16] = '{8'd9, 8'd21, 8'd105, 8'd134, 8'd7, 8'd3, 8'd19, 8'd29,
                             8'd14, 8'd27, 8'd8, 8'd20, 8'd24, 8'd30, 8'd40, 8'd36};
   logic [7:0] zeros [16];
   logic [7:0] alt [16];

   initial begin
      int cnt;
      for (int i = 0; i < 16; i++) zeros[i] = 8'h00;

      // reset state
      reset = 0; tick(); tick();
      chk("rst_trig", 32'(trigger), 0);
      chk("rst_data", 32'(data_out), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_res", 32'(result_q), 0);
      chk("rst_err", 32'(error), 0);
      reset = 1;

      // load buffer and stream, with ignored write/start/finished mid-stream
      for (int i = 0; i < 16; i++) begin
         wr_en = 1; wr_addr = 4'(i); wr_data = vals[i]; tick();
      end
      wr_en = 0; start = 1; tick(); start = 0;
      chk("start_latency", 32'(trigger), 1);
      cnt = 0;
      for (int c = 0; c < 40 && trigger === 1'b1; c++) begin
         if (cnt < 16) chk("s1_data", 32'(data_out), 32'(vals[cnt]));
         cnt++;
         wr_en = (cnt == 3); wr_addr = 4'd3; wr_data = 8'hFF; start = (cnt == 3);
         finished = (cnt == 6); result_in = 8'd55;
         tick();
      end
      wr_en = 0; start = 0; finished = 0;
      chk("s1_len", 32'(cnt), 16);
      chk("stray_res", 32'(result_q), 0);
      chk("stray_done", 32'(done), 0);
      chk("wait_busy", 32'(busy), 1);
      tick(); tick(); tick();
      finish_wait(8'd77);

      // rerun: buf[3] still 134, no restart happened
      start = 1; tick(); start = 0;
      run_stream("s2", vals);
      finish_wait(8'd200);

      // write coinciding with start is streamed
      alt = vals; alt[0] = 8'hAB;
      wr_en = 1; wr_addr = 0; wr_data = 8'hAB; start = 1; tick();
      wr_en = 0; start = 0;
      run_stream("s3", alt);
      finish_wait(8'd12);

      // reset abort at idx=5
      start = 1; tick(); start = 0;
      for (int i = 0; i < 5; i++) tick();
      reset = 0; tick(); reset = 1;
      chk("abort_trig", 32'(trigger), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_res", 32'(result_q), 0);
      start = 1; tick(); start = 0;
      run_stream("s4", zeros);
      finish_wait(8'd99);

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         reset     = ($urandom_range(0, 299) != 0);
         wr_en     = ($urandom_range(0, 1) == 1);
         wr_addr   = 4'($urandom_range(0, 15));
         wr_data   = 8'($urandom);
         start     = ($urandom_range(0, 7) == 0);
         finished  = ($urandom_range(0, 5) == 0);
         result_in = 8'($urandom);
         tick();
      end
      wr_en = 0; start = 0; finished = 0;
      reset = 0; tick(); reset = 1;

`ifdef MATRIX_FEEDER_TIMEOUT_EN
      begin
         logic [7:0] r0;
         int n;
         start = 1; tick(); start = 0;
         run_stream("s5", zeros);
         finish_wait(8'd66);
         r0 = result_q;
         start = 1; tick(); start = 0;
         run_stream("s6", zeros);
         n = 0;
         while (busy === 1'b1 && n < 300) begin n++; tick(); end
         chk("tmo_len", 32'(n), 256);
         chk("tmo_err", 32'(error), 1);
         chk("tmo_busy", 32'(busy), 0);
         chk("tmo_res", 32'(result_q), 32'(r0));
         tick();
         chk("tmo_sticky", 32'(error), 1);
         start = 1; tick(); start = 0;
         chk("tmo_clear", 32'(error), 0);
         run_stream("s7", zeros);
         finish_wait(8'd5);
      end
`endif

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
